// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - sequential double-dabble binary-to-BCD converter with leading-zero blanking
module score_bcd_display #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      score,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  update
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WIDTH-1:0]       last_score;
    logic [WIDTH-1:0]       bin_sr;
    logic [BW-1:0]          bcd_sr;
    logic [BW-1:0]          bcd_adj;
    logic [BW+WIDTH-1:0]    shifted;
    logic [CW-1:0]          cnt;
    logic [DIGITS-1:0]      blank_next;
    logic                   higher_zero;
    logic                   start;

    // A new conversion starts only for a changed score while not paused
    assign start   = !hold && (score != last_score);
    assign busy    = (state != IDLE);
    assign shifted = {bcd_adj, bin_sr} << 1;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: exactly WIDTH shift cycles, then one DONE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5, all evaluated on pre-shift values
    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            bcd_adj[4*d +: 4] = (bcd_sr[4*d +: 4] >= 4'd5) ? bcd_sr[4*d +: 4] + 4'd3
                                                           : bcd_sr[4*d +: 4];
        end
    end

    // Leading-zero flags: digit i blanks when it and every higher digit are zero; ones never blank
    always_comb begin
        blank_next  = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero && (bcd_sr[4*i +: 4] == 4'd0);
            blank_next[i] = higher_zero;
        end
    end

    // Datapath: capture, shift, and atomic publish of the finished result
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_score <= '0;
            bin_sr     <= '0;
            bcd_sr     <= '0;
            cnt        <= '0;
            digits     <= '0;
            blank      <= {{(DIGITS-1){1'b1}}, 1'b0};
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr     <= score;
                        last_score <= score;
                        bcd_sr     <= '0;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted[BW+WIDTH-1:WIDTH];
                    bin_sr <= shifted[WIDTH-1:0];
                    cnt    <= cnt + CW'(1);
                end
                DONE: begin
                    digits <= bcd_sr;
                    blank  <= blank_next;
                    update <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_display.sv
// tb/tb_score_bcd_display.sv - directed self-checking bench for score_bcd_display
module tb_score_bcd_display;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  score;
    logic        hold;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        busy;
    logic        update;

    int n_vec  = 0;
    int n_miss = 0;

    int          tv_val [8] = '{123, 1023, 7, 0, 1000, 10, 100, 9};
    logic [15:0] tv_dig [8] = '{16'h0123, 16'h1023, 16'h0007, 16'h0000,
                                16'h1000, 16'h0010, 16'h0100, 16'h0009};
    logic [3:0]  tv_blk [8] = '{4'b1000, 4'b0000, 4'b1110, 4'b1110,
                                4'b0000, 4'b1100, 4'b1000, 4'b1110};

    score_bcd_display #(.WIDTH(10), .DIGITS(4)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .score  (score),
        .hold   (hold),
        .digits (digits),
        .blank  (blank),
        .busy   (busy),
        .update (update)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Counts negedges until update is seen; lat = -1 when the budget runs out
    task automatic run_until_update(input int budget, output int lat, output int busy_cyc);
        lat      = -1;
        busy_cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge Clk);
            if (busy) busy_cyc++;
            if (update) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        Reset = 1'b1;
        score = 10'd0;
        hold  = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        n_vec++;
        if (digits !== 16'h0000) begin n_miss++; $display("FAIL reset_digits: got %h want 0000", digits); end
        n_vec++;
        if (blank !== 4'b1110) begin n_miss++; $display("FAIL reset_blank: got %b want 1110", blank); end
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge Clk);
            if (update !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_miss++; $display("FAIL reset_idle: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_convert_table();
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            score = 10'(tv_val[i]);
            run_until_update(40, lat, bc);
            n_vec++;
            if (lat != 12) begin n_miss++; $display("FAIL conv_latency[%0d]: got %0d want 12", i, lat); end
            n_vec++;
            if (bc != 11) begin n_miss++; $display("FAIL conv_busy_cycles[%0d]: got %0d want 11", i, bc); end
            n_vec++;
            if (digits !== tv_dig[i]) begin n_miss++; $display("FAIL conv_digits[%0d]: got %h want %h", i, digits, tv_dig[i]); end
            n_vec++;
            if (blank !== tv_blk[i]) begin n_miss++; $display("FAIL conv_blank[%0d]: got %b want %b", i, blank, tv_blk[i]); end
            @(negedge Clk);
            n_vec++;
            if (update !== 1'b0 || busy !== 1'b0) begin
                n_miss++;
                $display("FAIL conv_after[%0d]: got update=%b busy=%b want 0 0", i, update, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        score = 10'd5;
        repeat (3) @(negedge Clk);
        score = 10'd999;
        run_until_update(40, lat, bc);
        n_vec++;
        if (lat != 9) begin n_miss++; $display("FAIL b2b_first_latency: got %0d want 9", lat); end
        n_vec++;
        if (digits !== 16'h0005) begin n_miss++; $display("FAIL b2b_first_digits: got %h want 0005", digits); end
        n_vec++;
        if (blank !== 4'b1110) begin n_miss++; $display("FAIL b2b_first_blank: got %b want 1110", blank); end
        @(negedge Clk);
        n_vec++;
        if (busy !== 1'b1 || update !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_restart: got busy=%b update=%b want 1 0", busy, update);
        end
        run_until_update(40, lat, bc);
        n_vec++;
        if (lat != 11) begin n_miss++; $display("FAIL b2b_second_latency: got %0d want 11", lat); end
        n_vec++;
        if (digits !== 16'h0999) begin n_miss++; $display("FAIL b2b_second_digits: got %h want 0999", digits); end
        n_vec++;
        if (blank !== 4'b1000) begin n_miss++; $display("FAIL b2b_second_blank: got %b want 1000", blank); end
        @(negedge Clk);
    endtask

    task automatic test_hold_mid_shift();
        int lat, bc;
        score = 10'd500;
        repeat (3) @(negedge Clk);
        hold = 1'b1;
        run_until_update(40, lat, bc);
        n_vec++;
        if (lat != 9) begin n_miss++; $display("FAIL hold_mid_latency: got %0d want 9", lat); end
        n_vec++;
        if (digits !== 16'h0500) begin n_miss++; $display("FAIL hold_mid_digits: got %h want 0500", digits); end
        n_vec++;
        if (blank !== 4'b1000) begin n_miss++; $display("FAIL hold_mid_blank: got %b want 1000", blank); end
        @(negedge Clk);
    endtask

    task automatic test_hold();
        int lat, bc, bad;
        hold  = 1'b1;
        score = 10'd42;
        bad   = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            if (busy !== 1'b0 || update !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_miss++; $display("FAIL hold_idle: got %0d active cycles want 0", bad); end
        n_vec++;
        if (digits !== 16'h0500) begin n_miss++; $display("FAIL hold_keep_digits: got %h want 0500", digits); end
        hold = 1'b0;
        run_until_update(40, lat, bc);
        n_vec++;
        if (lat != 12) begin n_miss++; $display("FAIL hold_release_latency: got %0d want 12", lat); end
        n_vec++;
        if (digits !== 16'h0042) begin n_miss++; $display("FAIL hold_release_digits: got %h want 0042", digits); end
        n_vec++;
        if (blank !== 4'b1100) begin n_miss++; $display("FAIL hold_release_blank: got %b want 1100", blank); end
        @(negedge Clk);
    endtask

    task automatic test_async_reset();
        int lat, bc, bad;
        score = 10'd300;
        @(posedge Clk);
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if (digits !== 16'h0000 || blank !== 4'b1110 || busy !== 1'b0 || update !== 1'b0) begin
            n_miss++;
            $display("FAIL async_reset_outputs: got digits=%h blank=%b busy=%b update=%b want 0000 1110 0 0",
                     digits, blank, busy, update);
        end
        score = 10'd0;
        @(negedge Clk);
        Reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (busy !== 1'b0 || update !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_miss++; $display("FAIL async_reset_quiet: got %0d active cycles want 0", bad); end
        score = 10'd88;
        run_until_update(40, lat, bc);
        n_vec++;
        if (lat != 12) begin n_miss++; $display("FAIL async_reset_latency: got %0d want 12", lat); end
        n_vec++;
        if (digits !== 16'h0088) begin n_miss++; $display("FAIL async_reset_digits: got %h want 0088", digits); end
        n_vec++;
        if (blank !== 4'b1100) begin n_miss++; $display("FAIL async_reset_blank: got %b want 1100", blank); end
    endtask

    initial begin
        test_reset();
        test_convert_table();
        test_back_to_back();
        test_hold_mid_shift();
        test_hold();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
